// File: rtl/cpu_pkg.sv
// Shared fetch-stage types and constants for the pipeline CPU.
package cpu_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        HOLD,
        ERROR
    } fetch_state_t;

    localparam int unsigned INSTR_BYTES  = 4;
    localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;

    // Fetch addresses are word aligned; low two bits are always forced to zero.
    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return {pc[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_timeout_counter.sv
// Counts FETCH cycles without Ack; expire flags the cycle that reaches TIMEOUT-1.
module fetch_timeout_counter #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = $clog2(TIMEOUT + 1)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             clear,
    input  logic             incr,
    output logic             expire,
    output logic [CNT_W-1:0] count
);

    always_comb begin
        expire = incr && (count == CNT_W'(TIMEOUT - 1));
    end

    always_ff @(posedge CLK) begin
        if (RST || clear) begin
            count <= '0;
        end else if (incr) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch-stage initiator of the ReadEnable/Ack instruction-memory protocol:
// owns the PC, registers one instruction for decode, handles stall/redirect/timeout.
module instruction_fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_VECTOR,
    parameter int unsigned TIMEOUT  = 16,
    parameter int unsigned CNT_W    = $clog2(TIMEOUT + 1)
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        Enable,
    input  logic        Stall,
    input  logic        Redirect,
    input  logic [31:0] RedirectPc,
    input  logic        Ack,
    input  logic [31:0] Instr,
    output logic        ReadEnable,
    output logic [31:0] Address,
    output logic        InstrValid,
    output logic [31:0] InstrOut,
    output logic [31:0] PcOut,
    output logic        FetchError
);

    fetch_state_t     state;
    logic [31:0]      pc;
    logic             discard;
    logic             tmo_clear;
    logic             tmo_incr;
    logic             tmo_expire;
    logic [CNT_W-1:0] tmo_count;

    assign Address = pc;

    always_comb begin
        tmo_incr  = (state == FETCH) && !Ack;
        tmo_clear = (state != FETCH) || Ack;
    end

    fetch_timeout_counter #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_timeout (
        .CLK    (CLK),
        .RST    (RST),
        .clear  (tmo_clear),
        .incr   (tmo_incr),
        .expire (tmo_expire),
        .count  (tmo_count)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            pc         <= align_pc(RESET_PC);
            discard    <= 1'b0;
            ReadEnable <= 1'b0;
            InstrValid <= 1'b0;
            InstrOut   <= '0;
            PcOut      <= '0;
            FetchError <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (Redirect) begin
                        pc <= align_pc(RedirectPc);
                    end
                    if (Enable) begin
                        state      <= FETCH;
                        ReadEnable <= 1'b1;
                    end
                end
                FETCH: begin
                    if (Ack) begin
                        if (discard || Redirect) begin
                            // Stale or flushed word: drop it and reissue at the current PC.
                            discard <= 1'b0;
                            if (Redirect) begin
                                pc <= align_pc(RedirectPc);
                            end
                        end else begin
                            InstrOut   <= Instr;
                            PcOut      <= pc;
                            InstrValid <= 1'b1;
                            pc         <= pc + 32'(INSTR_BYTES);
                            state      <= HOLD;
                            ReadEnable <= 1'b0;
                        end
                    end else if (tmo_expire) begin
                        state      <= ERROR;
                        ReadEnable <= 1'b0;
                        FetchError <= 1'b1;
                        InstrValid <= 1'b0;
                    end else if (Redirect) begin
                        // The outstanding request cannot be aborted; mark its data stale.
                        pc      <= align_pc(RedirectPc);
                        discard <= 1'b1;
                    end
                end
                HOLD: begin
                    if (Redirect || !Stall) begin
                        InstrValid <= 1'b0;
                        if (Redirect) begin
                            pc <= align_pc(RedirectPc);
                        end
                        if (Enable) begin
                            state      <= FETCH;
                            ReadEnable <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                ERROR: begin
                    ReadEnable <= 1'b0;
                    InstrValid <= 1'b0;
                    FetchError <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
